// File: rtl/fns_cac_pkg.sv
// Shared types and helpers for the FNS crosstalk-avoidance TSV encoder.
// Holds the FSM state type, the saturating adder and the default widths.
package fns_cac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ENC  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_CODE_W = 6;
    localparam int DEF_ACC_W  = DEF_DATA_W + 2;
    localparam int SAT_MAX_W  = 32;

    // Callers zero-extend into SAT_MAX_W and truncate the result back to acc_w.
    function automatic logic [SAT_MAX_W-1:0] sat_add(
        input logic [SAT_MAX_W-1:0] a,
        input logic [SAT_MAX_W-1:0] b,
        input int unsigned          acc_w
    );
        logic [SAT_MAX_W:0] sum;
        logic [SAT_MAX_W:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = ({{SAT_MAX_W{1'b0}}, 1'b1} << acc_w) - 1'b1;
        return (sum > lim) ? lim[SAT_MAX_W-1:0] : sum[SAT_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/fns_weight_gen.sv
// Combinational Fibonacci weight table over the enabled TSVs plus their total capacity.
// Disabled positions get weight 0; the chain restarts its spacing only over healthy lanes.
module fns_weight_gen
    import fns_cac_pkg::*;
#(
    parameter int CODE_W = DEF_CODE_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic [CODE_W-1:0] i_en,
    output logic [ACC_W-1:0]  o_w [CODE_W],
    output logic [ACC_W-1:0]  o_cap
);

    always_comb begin
        logic [ACC_W-1:0] nxt;
        logic [ACC_W-1:0] prv;
        logic [ACC_W-1:0] tmp;
        logic [ACC_W-1:0] cap;
        nxt = ACC_W'(1);
        prv = '0;
        tmp = '0;
        cap = '0;
        for (int i = 0; i < CODE_W; i++) begin
            o_w[i] = '0;
            if (i_en[i]) begin
                o_w[i] = nxt;
                cap    = ACC_W'(sat_add(SAT_MAX_W'(cap), SAT_MAX_W'(nxt), unsigned'(ACC_W)));
                tmp    = ACC_W'(sat_add(SAT_MAX_W'(nxt), SAT_MAX_W'(prv), unsigned'(ACC_W)));
                prv    = nxt;
                nxt    = tmp;
            end
        end
        o_cap = cap;
    end

endmodule

// File: rtl/fns_cac_encoder_seq.sv
// Sequential FNS crosstalk-avoidance encoder: greedy, one code bit per cycle, MSB first.
// Optional FNS_CAC_SELFCHECK_EN adds chk_err, a decode-back comparison while in DONE.
module fns_cac_encoder_seq
    import fns_cac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CODE_W = DEF_CODE_W,
    parameter int ACC_W  = DATA_W + 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] datain,
    input  logic [CODE_W-1:0] en_flag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] codeout,
`ifdef FNS_CAC_SELFCHECK_EN
    output logic              chk_err,
`endif
    output logic              ovf
);

    localparam int IDX_W = $clog2(CODE_W);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [CODE_W-1:0] r_en;
    logic [ACC_W-1:0]  r_w [CODE_W];
    logic [ACC_W-1:0]  r_rem;
    logic [IDX_W-1:0]  r_idx;
    logic [CODE_W-1:0] r_code;
    logic              r_ovf;
    logic [ACC_W-1:0]  w_w [CODE_W];
    logic [ACC_W-1:0]  w_cap;
    logic              w_bit;
    logic              w_accept;

    fns_weight_gen #(.CODE_W(CODE_W), .ACC_W(ACC_W)) u_weight_gen (
        .i_en  (en_flag),
        .o_w   (w_w),
        .o_cap (w_cap)
    );

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign codeout   = r_code;
    assign ovf       = r_ovf;
    assign w_accept  = in_valid && in_ready;

    // On overflow every enabled lane is driven high, still spending one cycle per bit.
    assign w_bit = r_ovf ? r_en[r_idx] : (r_en[r_idx] && (r_rem >= r_w[r_idx]));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)       w_state_nxt = ST_ENC;
            ST_ENC:  if (r_idx == '0)    w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready)      w_state_nxt = ST_IDLE;
            default:                     w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_en    <= '0;
            r_rem   <= '0;
            r_idx   <= '0;
            r_code  <= '0;
            r_ovf   <= 1'b0;
            for (int i = 0; i < CODE_W; i++) r_w[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_en   <= en_flag;
                r_w    <= w_w;
                r_rem  <= ACC_W'(datain);
                r_idx  <= IDX_W'(CODE_W - 1);
                r_code <= '0;
                r_ovf  <= (ACC_W'(datain) > w_cap);
            end else if (r_state == ST_ENC) begin
                r_code[r_idx] <= w_bit;
                if (w_bit && !r_ovf) r_rem <= r_rem - r_w[r_idx];
                if (r_idx != '0) r_idx <= r_idx - 1'b1;
            end
        end
    end

`ifdef FNS_CAC_SELFCHECK_EN
    logic [DATA_W-1:0] r_data;
    logic [ACC_W-1:0]  w_dec;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)      r_data <= '0;
        else if (w_accept) r_data <= datain;
    end

    always_comb begin
        w_dec = '0;
        for (int i = 0; i < CODE_W; i++) begin
            if (r_code[i])
                w_dec = ACC_W'(sat_add(SAT_MAX_W'(w_dec), SAT_MAX_W'(r_w[i]), unsigned'(ACC_W)));
        end
    end

    assign chk_err = (r_state == ST_DONE) && (w_dec != ACC_W'(r_data)) && !r_ovf;
`endif

endmodule

// File: tb/tb_fns_cac_encoder_seq.sv
// Self-checking bench for fns_cac_encoder_seq (DATA_W=4, CODE_W=6).
// Expected codes come from an integer Fibonacci/greedy reference model.
module tb_fns_cac_encoder_seq;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] datain = '0;
    logic [5:0] en_flag = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [5:0] codeout;
    logic       ovf;
`ifdef FNS_CAC_SELFCHECK_EN
    logic       chk_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    fns_cac_encoder_seq #(.DATA_W(4), .CODE_W(6)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .datain    (datain),
        .en_flag   (en_flag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .codeout   (codeout),
`ifdef FNS_CAC_SELFCHECK_EN
        .chk_err   (chk_err),
`endif
        .ovf       (ovf)
    );

    // Weights 1,1,2,3,5,8,... over enabled lanes; greedy from the top lane down.
    function automatic void model(input logic [5:0] en, input int d,
                                  output logic [5:0] code, output logic ov);
        int w[6];
        int a = 1, b = 0, t, cap = 0, rem;
        for (int i = 0; i < 6; i++) begin
            w[i] = 0;
            if (en[i]) begin
                w[i] = a;
                cap = (cap + a > 63) ? 63 : cap + a;
                t = (a + b > 63) ? 63 : a + b;
                b = a;
                a = t;
            end
        end
        code = '0;
        ov = (d > cap);
        if (ov) code = en;
        else begin
            rem = d;
            for (int i = 5; i >= 0; i--) begin
                if (en[i] && rem >= w[i]) begin
                    code[i] = 1'b1;
                    rem -= w[i];
                end
            end
        end
    endfunction

    // Drives one word, waits for out_valid (bounded), captures outputs, then releases it.
    task automatic send_word(input logic [3:0] d, input logic [5:0] e,
                             output logic [5:0] c, output logic o, output int lat);
        @(negedge clock);
        in_valid = 1'b1; datain = d; en_flag = e; out_ready = 1'b0;
        @(posedge clock); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clock); #1;
            lat++;
        end
        c = codeout;
        o = ovf;
`ifdef FNS_CAC_SELFCHECK_EN
        checks++;
        if (chk_err !== 1'b0) begin
            errors++;
            $display("FAIL chk_err d=%0d en=%h got %b want 0", d, e, chk_err);
        end
`endif
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({in_ready, out_valid, codeout, ovf} !== {1'b1, 1'b0, 6'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got rdy=%b vld=%b code=%h ovf=%b want 1 0 00 0",
                     in_ready, out_valid, codeout, ovf);
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [3:0] vd [9] = '{4'd15, 4'd7, 4'd0, 4'd10, 4'd15, 4'd12, 4'd0, 4'd5, 4'd1};
        logic [5:0] ve [9] = '{6'h3F, 6'h3F, 6'h3F, 6'h3B, 6'h3B, 6'h3B, 6'h00, 6'h00, 6'h01};
        logic [5:0] vc [9] = '{6'h34, 6'h14, 6'h00, 6'h38, 6'h3B, 6'h3B, 6'h00, 6'h00, 6'h01};
        logic       vo [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [5:0] c;
        logic o;
        int lat;
        for (int k = 0; k < 9; k++) begin
            send_word(vd[k], ve[k], c, o, lat);
            checks++;
            if (c !== vc[k] || o !== vo[k]) begin
                errors++;
                $display("FAIL directed_%0d d=%0d en=%h got code=%h ovf=%b want code=%h ovf=%b",
                         k, vd[k], ve[k], c, o, vc[k], vo[k]);
            end
            checks++;
            if (lat != 6) begin
                errors++;
                $display("FAIL latency_%0d got %0d want 6", k, lat);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] d;
        logic [5:0] e, c, ec;
        logic o, eo;
        int lat;
        for (int k = 0; k < 200; k++) begin
            d = 4'($urandom_range(0, 15));
            e = ($urandom_range(0, 3) == 0) ? 6'h3F : 6'($urandom);
            model(e, int'(d), ec, eo);
            send_word(d, e, c, o, lat);
            checks++;
            if (c !== ec || o !== eo || lat != 6) begin
                errors++;
                $display("FAIL random_%0d d=%0d en=%h got code=%h ovf=%b lat=%0d want code=%h ovf=%b lat=6",
                         k, d, e, c, o, lat, ec, eo);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [5:0] c0, ec;
        logic o0, eo;
        int lat;
        model(6'h3B, 15, ec, eo);
        @(negedge clock);
        in_valid = 1'b1; datain = 4'd15; en_flag = 6'h3B; out_ready = 1'b0;
        @(posedge clock); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clock); #1;
            lat++;
        end
        c0 = codeout;
        o0 = ovf;
        checks++;
        if (c0 !== ec || o0 !== eo || lat != 6) begin
            errors++;
            $display("FAIL bp_first got code=%h ovf=%b lat=%0d want code=%h ovf=%b lat=6",
                     c0, o0, lat, ec, eo);
        end
        @(negedge clock);
        in_valid = 1'b1; datain = 4'd3; en_flag = 6'h3F;
        for (int k = 0; k < 5; k++) begin
            @(posedge clock); #1;
            checks++;
            if (codeout !== c0 || ovf !== o0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d got code=%h ovf=%b vld=%b rdy=%b want code=%h ovf=%b vld=1 rdy=0",
                         k, codeout, ovf, out_valid, in_ready, c0, o0);
            end
        end
        @(negedge clock);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        repeat (8) @(posedge clock);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ignored got vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int acc[$];
        @(negedge clock);
        in_valid = 1'b1; datain = 4'd9; en_flag = 6'h3F; out_ready = 1'b1;
        for (int cyc = 0; cyc < 32; cyc++) begin
            if (in_ready) acc.push_back(cyc);
            @(negedge clock);
            datain = 4'($urandom_range(0, 15));
        end
        in_valid = 1'b0;
        checks++;
        if (acc.size() != 4) begin
            errors++;
            $display("FAIL b2b_count got %0d want 4", acc.size());
        end
        for (int k = 1; k < acc.size(); k++) begin
            checks++;
            if (acc[k] - acc[k-1] != 8) begin
                errors++;
                $display("FAIL b2b_gap_%0d got %0d want 8", k, acc[k] - acc[k-1]);
            end
        end
        repeat (10) @(posedge clock);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [5:0] c;
        logic o;
        int lat, seen;
        @(negedge clock);
        in_valid = 1'b1; datain = 4'd15; en_flag = 6'h3F;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, codeout, ovf} !== {1'b1, 1'b0, 6'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid got rdy=%b vld=%b code=%h ovf=%b want 1 0 00 0",
                     in_ready, out_valid, codeout, ovf);
        end
        @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(posedge clock); #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_stale got %0d valid cycles want 0", seen);
        end
        send_word(4'd7, 6'h3F, c, o, lat);
        checks++;
        if (c !== 6'h14 || o !== 1'b0 || lat != 6) begin
            errors++;
            $display("FAIL reset_next got code=%h ovf=%b lat=%0d want 14 0 6", c, o, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
